// File: rtl/spi_share_arb.sv
// -----------------------------------------------------------------------------
// spi_share_arb
//
// Shares one byte-wide SPI shift engine (SPI mode 0, MSB first) between four
// requesters: Z80 SD port, DMA SD fetch, MP3 control (MC) and MP3 data (MD).
// Each requester has a pending flag and a data latch. Grants are by fixed
// priority MC > DMA SD > Z80 SD > MD, and each byte is shifted at the
// requester's own SCK half-period.
//
// Optional feature macro: SPI_ARB_ANTISTARVE_EN
//   When defined, three consecutive non-MD grants while MD is pending force
//   the next grant to MD. When undefined, arbitration is pure fixed priority.
//
// Ports
//   cpu_clock      system clock
//   rst_n          asynchronous active-low reset
//   sd_start       Z80 SD strobe, sd_din sampled with it
//   dma_sd_start   DMA SD fetch strobe, transmits 8'hFF
//   mc_start       MC strobe, mc_din sampled with it
//   mc_speed       MC half-period: 00 = MC_SLOW_DIV, 01 = 4, 1x = 1
//   md_start       MD strobe, md_din sampled with it
//   md_halfspeed   MD half-period: 1 = 2 clocks, 0 = 1 clock
//   spi_miso       shared serial input
//   spi_sck        shared serial clock (idles low)
//   spi_mosi       shared serial output (idles high)
//   spi_tgt        active target: 0 idle, 1 SD, 2 MC, 3 MD
//   sd_dout        last SD received byte (Z80 or DMA)
//   mc_dout        last MC received byte
//   sd_rdy         no SD request (Z80 or DMA) pending or active
//   mc_rdy         no MC request pending or active
//   dma_sd_done    one-cycle pulse when a DMA byte lands in sd_dout
//   ovr            one-cycle pulse, the cycle after a start was dropped
//
// State table
//   state  | meaning
//   IDLE   | no transfer; a pending request is granted here
//   LOAD   | target driven, MOSI = bit 7, half-period selected
//   SHIFT  | 16 half-periods; SCK high on odd ones, MISO sampled on rise
//   DONE   | received byte written to its dout, then back to IDLE
// -----------------------------------------------------------------------------
module spi_share_arb #(
    parameter int MC_SLOW_DIV = 8
) (
    input  logic       cpu_clock,
    input  logic       rst_n,
    input  logic       sd_start,
    input  logic [7:0] sd_din,
    input  logic       dma_sd_start,
    input  logic       mc_start,
    input  logic [7:0] mc_din,
    input  logic [1:0] mc_speed,
    input  logic       md_start,
    input  logic [7:0] md_din,
    input  logic       md_halfspeed,
    input  logic       spi_miso,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic [1:0] spi_tgt,
    output logic [7:0] sd_dout,
    output logic [7:0] mc_dout,
    output logic       sd_rdy,
    output logic       mc_rdy,
    output logic       dma_sd_done,
    output logic       ovr
);

    // Counter must also hold the fixed divide-by-4 reload for small MC_SLOW_DIV.
    localparam int CW = ($clog2(MC_SLOW_DIV) + 1 < 3) ? 3 : $clog2(MC_SLOW_DIV) + 1;
    // Counters hold H-1 so that H can never be 0.
    localparam logic [CW-1:0] L_SLOW_RL = (MC_SLOW_DIV > 1) ? CW'(MC_SLOW_DIV - 1) : '0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] G_Z80 = 2'd0;
    localparam logic [1:0] G_DMA = 2'd1;
    localparam logic [1:0] G_MC  = 2'd2;
    localparam logic [1:0] G_MD  = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    r_gnt;
    logic          r_sd_pend;
    logic          r_dma_pend;
    logic          r_mc_pend;
    logic          r_md_pend;
    logic [7:0]    r_sd_data;
    logic [7:0]    r_mc_data;
    logic [7:0]    r_md_data;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;
    logic          r_mosi;
    logic          r_sck;
    logic [1:0]    r_tgt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_half;
    logic [3:0]    r_hp;
    logic [7:0]    r_sd_dout;
    logic [7:0]    r_mc_dout;
    logic          r_dma_done;
    logic          r_ovr;

    logic          w_grant;
    logic [1:0]    w_gnt_id;
    logic [7:0]    w_gnt_data;
    logic [1:0]    w_gnt_tgt;
    logic [CW-1:0] w_half;
    logic          w_force_md;
    logic          w_sd_active;
    logic          w_mc_active;

`ifdef SPI_ARB_ANTISTARVE_EN
    logic [1:0] r_starve;

    assign w_force_md = r_md_pend && (r_starve == 2'd3);

    always_ff @(posedge cpu_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= 2'd0;
        end else if (!r_md_pend) begin
            r_starve <= 2'd0;
        end else if (w_grant) begin
            if (w_gnt_id == G_MD)
                r_starve <= 2'd0;
            else if (r_starve != 2'd3)
                r_starve <= r_starve + 2'd1;
        end
    end
`else
    assign w_force_md = 1'b0;
`endif

    // Arbitration only happens in IDLE, so pending flags clear on the same
    // edge that enters LOAD.
    always_comb begin
        w_grant  = 1'b0;
        w_gnt_id = G_Z80;
        if (r_state == S_IDLE) begin
            if (w_force_md) begin
                w_grant  = 1'b1;
                w_gnt_id = G_MD;
            end else if (r_mc_pend) begin
                w_grant  = 1'b1;
                w_gnt_id = G_MC;
            end else if (r_dma_pend) begin
                w_grant  = 1'b1;
                w_gnt_id = G_DMA;
            end else if (r_sd_pend) begin
                w_grant  = 1'b1;
                w_gnt_id = G_Z80;
            end else if (r_md_pend) begin
                w_grant  = 1'b1;
                w_gnt_id = G_MD;
            end
        end
    end

    always_comb begin
        w_gnt_data = 8'hFF;
        w_gnt_tgt  = 2'd1;
        case (w_gnt_id)
            G_Z80: begin w_gnt_data = r_sd_data; w_gnt_tgt = 2'd1; end
            G_DMA: begin w_gnt_data = 8'hFF;     w_gnt_tgt = 2'd1; end
            G_MC:  begin w_gnt_data = r_mc_data; w_gnt_tgt = 2'd2; end
            default: begin w_gnt_data = r_md_data; w_gnt_tgt = 2'd3; end
        endcase
    end

    // Speed inputs are only looked at while in LOAD.
    always_comb begin
        w_half = '0;
        if (r_gnt == G_MC) begin
            case (mc_speed)
                2'b00:   w_half = L_SLOW_RL;
                2'b01:   w_half = CW'(3);
                default: w_half = '0;
            endcase
        end else if (r_gnt == G_MD) begin
            w_half = md_halfspeed ? CW'(1) : '0;
        end
    end

    // A start seen while its own pending flag is set is dropped. Grant needs
    // pending set and capture needs it clear, so the two never collide.
    always_ff @(posedge cpu_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sd_pend  <= 1'b0;
            r_dma_pend <= 1'b0;
            r_mc_pend  <= 1'b0;
            r_md_pend  <= 1'b0;
            r_sd_data  <= 8'hFF;
            r_mc_data  <= 8'hFF;
            r_md_data  <= 8'hFF;
            r_ovr      <= 1'b0;
        end else begin
            r_ovr <= (sd_start && r_sd_pend) || (dma_sd_start && r_dma_pend) ||
                     (mc_start && r_mc_pend) || (md_start && r_md_pend);

            if (!r_sd_pend) begin
                if (sd_start) begin
                    r_sd_pend <= 1'b1;
                    r_sd_data <= sd_din;
                end
            end else if (w_grant && w_gnt_id == G_Z80) begin
                r_sd_pend <= 1'b0;
            end

            if (!r_dma_pend) begin
                if (dma_sd_start)
                    r_dma_pend <= 1'b1;
            end else if (w_grant && w_gnt_id == G_DMA) begin
                r_dma_pend <= 1'b0;
            end

            if (!r_mc_pend) begin
                if (mc_start) begin
                    r_mc_pend <= 1'b1;
                    r_mc_data <= mc_din;
                end
            end else if (w_grant && w_gnt_id == G_MC) begin
                r_mc_pend <= 1'b0;
            end

            if (!r_md_pend) begin
                if (md_start) begin
                    r_md_pend <= 1'b1;
                    r_md_data <= md_din;
                end
            end else if (w_grant && w_gnt_id == G_MD) begin
                r_md_pend <= 1'b0;
            end
        end
    end

    // r_hp indexes the 16 half-periods from 0; even index = SCK high.
    always_ff @(posedge cpu_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= G_Z80;
            r_tgt      <= 2'd0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b1;
            r_tx       <= 8'hFF;
            r_rx       <= 8'hFF;
            r_cnt      <= '0;
            r_half     <= '0;
            r_hp       <= 4'd0;
            r_sd_dout  <= 8'hFF;
            r_mc_dout  <= 8'hFF;
            r_dma_done <= 1'b0;
        end else begin
            r_dma_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state <= S_LOAD;
                        r_gnt   <= w_gnt_id;
                        r_tgt   <= w_gnt_tgt;
                        r_tx    <= w_gnt_data;
                        r_mosi  <= w_gnt_data[7];
                    end
                end
                S_LOAD: begin
                    r_state <= S_SHIFT;
                    r_half  <= w_half;
                    r_cnt   <= w_half;
                    r_hp    <= 4'd0;
                    r_sck   <= 1'b1;
                    r_rx    <= {r_rx[6:0], spi_miso};
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_cnt <= r_half;
                        if (r_hp == 4'd15) begin
                            r_state <= S_DONE;
                            if (r_gnt == G_MC)
                                r_mc_dout <= r_rx;
                            else if (r_gnt != G_MD)
                                r_sd_dout <= r_rx;
                            r_dma_done <= (r_gnt == G_DMA);
                        end else begin
                            r_hp <= r_hp + 4'd1;
                            if (!r_hp[0]) begin
                                // falling edge: advance MOSI, fill with ones
                                r_sck  <= 1'b0;
                                r_tx   <= {r_tx[6:0], 1'b1};
                                r_mosi <= r_tx[6];
                            end else begin
                                r_sck <= 1'b1;
                                r_rx  <= {r_rx[6:0], spi_miso};
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tgt   <= 2'd0;
                    r_mosi  <= 1'b1;
                end
            endcase
        end
    end

    assign w_sd_active = (r_state != S_IDLE) && (r_gnt == G_Z80 || r_gnt == G_DMA);
    assign w_mc_active = (r_state != S_IDLE) && (r_gnt == G_MC);

    assign sd_rdy      = !(r_sd_pend || r_dma_pend || w_sd_active);
    assign mc_rdy      = !(r_mc_pend || w_mc_active);
    assign spi_sck     = r_sck;
    assign spi_mosi    = r_mosi;
    assign spi_tgt     = r_tgt;
    assign sd_dout     = r_sd_dout;
    assign mc_dout     = r_mc_dout;
    assign dma_sd_done = r_dma_done;
    assign ovr         = r_ovr;

endmodule

// File: tb/tb_spi_share_arb.sv
// -----------------------------------------------------------------------------
// tb_spi_share_arb
//
// Directed bench for spi_share_arb. A monitor reconstructs every byte seen on
// the SPI pins (target, MOSI byte, SCK-high cycle count) into obs_q; the
// stimulus pushes the expected record into exp_q when it issues a start.
// A simple slave shifts a 32-bit MISO pattern out on SCK falling edges.
// -----------------------------------------------------------------------------
module tb_spi_share_arb;

    logic       cpu_clock = 1'b0;
    logic       rst_n;
    logic       sd_start, dma_sd_start, mc_start, md_start;
    logic [7:0] sd_din, mc_din, md_din;
    logic [1:0] mc_speed;
    logic       md_halfspeed;
    logic       spi_miso;
    logic       spi_sck, spi_mosi;
    logic [1:0] spi_tgt;
    logic [7:0] sd_dout, mc_dout;
    logic       sd_rdy, mc_rdy, dma_sd_done, ovr;

    spi_share_arb #(.MC_SLOW_DIV(8)) dut (
        .cpu_clock   (cpu_clock),
        .rst_n       (rst_n),
        .sd_start    (sd_start),
        .sd_din      (sd_din),
        .dma_sd_start(dma_sd_start),
        .mc_start    (mc_start),
        .mc_din      (mc_din),
        .mc_speed    (mc_speed),
        .md_start    (md_start),
        .md_din      (md_din),
        .md_halfspeed(md_halfspeed),
        .spi_miso    (spi_miso),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_tgt     (spi_tgt),
        .sd_dout     (sd_dout),
        .mc_dout     (mc_dout),
        .sd_rdy      (sd_rdy),
        .mc_rdy      (mc_rdy),
        .dma_sd_done (dma_sd_done),
        .ovr         (ovr)
    );

    always #5 cpu_clock = ~cpu_clock;

    typedef struct {
        logic [1:0] tgt;
        logic [7:0] tx;
        int         hi;
    } xfer_t;

    xfer_t      exp_q[$];
    xfer_t      obs_q[$];
    logic [1:0] tgt_log[$];
    int         vectors = 0;
    int         miscompares = 0;

    // SPI slave
    int          fall_cnt = 0;
    int          base_cnt = 0;
    logic [31:0] base_pat = 32'hFFFF_FFFF;
    int          miso_idx;

    always @(negedge spi_sck) fall_cnt = fall_cnt + 1;
    assign miso_idx = fall_cnt - base_cnt;
    assign spi_miso = (miso_idx >= 0 && miso_idx < 32) ? base_pat[5'(31 - miso_idx)] : 1'b1;

    // Pin monitor, sampled on the falling clock edge
    xfer_t      m_cur;
    logic       m_act = 1'b0;
    logic       m_prev_sck = 1'b0;
    logic [1:0] m_prev_tgt = 2'd0;

    always @(negedge cpu_clock) begin
        if (!rst_n) begin
            m_act      = 1'b0;
            m_prev_sck = 1'b0;
            m_prev_tgt = 2'd0;
        end else begin
            if (spi_tgt != m_prev_tgt) tgt_log.push_back(spi_tgt);
            if (!m_act && spi_tgt != 2'd0) begin
                m_act     = 1'b1;
                m_cur.tgt = spi_tgt;
                m_cur.tx  = 8'h00;
                m_cur.hi  = 0;
            end
            if (m_act) begin
                if (spi_sck) m_cur.hi = m_cur.hi + 1;
                if (spi_sck && !m_prev_sck) m_cur.tx = {m_cur.tx[6:0], spi_mosi};
                if (spi_tgt == 2'd0) begin
                    obs_q.push_back(m_cur);
                    m_act = 1'b0;
                end
            end
            m_prev_sck = spi_sck;
            m_prev_tgt = spi_tgt;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_miso(input logic [31:0] pat);
        base_pat = pat;
        base_cnt = fall_cnt;
    endtask

    task automatic exp_push(input logic [1:0] tgt, input logic [7:0] tx, input int hi);
        xfer_t e;
        e.tgt = tgt;
        e.tx  = tx;
        e.hi  = hi;
        exp_q.push_back(e);
    endtask

    // mask: bit0 sd, bit1 dma, bit2 mc, bit3 md. Returns 1 time unit after
    // the edge that samples the strobes.
    task automatic drive_start(input logic [3:0] mask);
        sd_start     = mask[0];
        dma_sd_start = mask[1];
        mc_start     = mask[2];
        md_start     = mask[3];
        @(posedge cpu_clock);
        #1;
        sd_start     = 1'b0;
        dma_sd_start = 1'b0;
        mc_start     = 1'b0;
        md_start     = 1'b0;
    endtask

    task automatic sb_check(input string tag);
        int    n;
        xfer_t o;
        xfer_t e;
        n = 0;
        while (obs_q.size() == 0 && n < 400) begin
            @(posedge cpu_clock);
            #1;
            n++;
        end
        chk({tag, "_seen"}, 32'(obs_q.size() > 0), 32'd1);
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_tgt"}, 32'(o.tgt), 32'(e.tgt));
            chk({tag, "_tx"},  32'(o.tx),  32'(e.tx));
            chk({tag, "_hi"},  32'(o.hi),  32'(e.hi));
        end
    endtask

    initial begin
        int         lat;
        int         n;
        int         pulses;
        int         at_cyc;
        logic [7:0] dout_at;
        logic [1:0] log_v[4];

        rst_n        = 1'b0;
        sd_start     = 1'b0;
        dma_sd_start = 1'b0;
        mc_start     = 1'b0;
        md_start     = 1'b0;
        sd_din       = 8'h00;
        mc_din       = 8'h00;
        md_din       = 8'h00;
        mc_speed     = 2'b10;
        md_halfspeed = 1'b0;

        // reset values
        repeat (3) @(posedge cpu_clock);
        #1;
        chk("rst_sck",  32'(spi_sck), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd1);
        chk("rst_tgt",  32'(spi_tgt), 32'd0);
        chk("rst_sd_dout", 32'(sd_dout), 32'hFF);
        chk("rst_mc_dout", 32'(mc_dout), 32'hFF);
        chk("rst_sd_rdy", 32'(sd_rdy), 32'd1);
        chk("rst_mc_rdy", 32'(mc_rdy), 32'd1);
        chk("rst_dma_done", 32'(dma_sd_done), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge cpu_clock);
        #1;

        // single Z80 transfer, H = 1
        set_miso(32'h3C00_0000);
        sd_din = 8'hA5;
        exp_push(2'd1, 8'hA5, 8);
        drive_start(4'b0001);
        chk("z80_rdy_low", 32'(sd_rdy), 32'd0);
        lat = 0;
        while (!sd_rdy && lat < 60) begin
            @(posedge cpu_clock);
            #1;
            lat++;
        end
        chk("z80_rdy_lat", 32'(lat), 32'd19);
        chk("z80_dout", 32'(sd_dout), 32'h3C);
        sb_check("z80");

        // simultaneous MC + SD: MC first
        tgt_log.delete();
        set_miso(32'h1EE1_0000);
        mc_speed = 2'b10;
        mc_din   = 8'h5A;
        sd_din   = 8'hC3;
        exp_push(2'd2, 8'h5A, 8);
        exp_push(2'd1, 8'hC3, 8);
        drive_start(4'b0101);
        n = 0;
        while (!(sd_rdy && mc_rdy) && n < 100) begin
            @(posedge cpu_clock);
            #1;
            n++;
        end
        chk("sim_done", 32'(sd_rdy && mc_rdy), 32'd1);
        chk("sim_mc_dout", 32'(mc_dout), 32'h1E);
        chk("sim_sd_dout", 32'(sd_dout), 32'hE1);
        sb_check("sim_mc");
        sb_check("sim_sd");
        @(posedge cpu_clock);
        #1;
        chk("sim_log_len", 32'(tgt_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) log_v[i] = (i < tgt_log.size()) ? tgt_log[i] : 2'bxx;
        chk("sim_log0", 32'(log_v[0]), 32'd2);
        chk("sim_log1", 32'(log_v[1]), 32'd0);
        chk("sim_log2", 32'(log_v[2]), 32'd1);
        chk("sim_log3", 32'(log_v[3]), 32'd0);

        // DMA fetch
        set_miso(32'h9600_0000);
        exp_push(2'd1, 8'hFF, 8);
        drive_start(4'b0010);
        pulses  = 0;
        at_cyc  = 0;
        dout_at = 8'h00;
        for (int k = 1; k <= 40; k++) begin
            @(posedge cpu_clock);
            #1;
            if (dma_sd_done) begin
                pulses++;
                at_cyc  = k;
                dout_at = sd_dout;
            end
        end
        chk("dma_pulses", 32'(pulses), 32'd1);
        chk("dma_pulse_cyc", 32'(at_cyc), 32'd18);
        chk("dma_dout", 32'(dout_at), 32'h96);
        sb_check("dma");

        // slow MC, speed change mid-byte ignored
        set_miso(32'h6900_0000);
        mc_speed = 2'b00;
        mc_din   = 8'h81;
        exp_push(2'd2, 8'h81, 64);
        drive_start(4'b0100);
        repeat (30) @(posedge cpu_clock);
        #1;
        mc_speed = 2'b10;
        lat = 30;
        while (!mc_rdy && lat < 400) begin
            @(posedge cpu_clock);
            #1;
            lat++;
        end
        chk("slow_rdy_lat", 32'(lat), 32'd131);
        chk("slow_dout", 32'(mc_dout), 32'h69);
        sb_check("slow");

        // MD overrun: second strobe while pending is dropped
        set_miso(32'hFFFF_FFFF);
        md_halfspeed = 1'b1;
        md_din       = 8'h3A;
        exp_push(2'd3, 8'h3A, 16);
        md_start = 1'b1;
        @(posedge cpu_clock);
        #1;
        md_din = 8'hC7;
        @(posedge cpu_clock);
        #1;
        md_start = 1'b0;
        pulses = ovr ? 1 : 0;
        chk("ovr_first", 32'(ovr), 32'd1);
        for (int k = 0; k < 60; k++) begin
            @(posedge cpu_clock);
            #1;
            if (ovr) pulses++;
        end
        chk("ovr_pulses", 32'(pulses), 32'd1);
        sb_check("ovr_md");

        // reset mid-SHIFT
        set_miso(32'hFFFF_FFFF);
        sd_din = 8'hF0;
        drive_start(4'b0001);
        repeat (6) @(posedge cpu_clock);
        #3;
        chk("pre_rst_sck", 32'(spi_sck), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_sck", 32'(spi_sck), 32'd0);
        chk("abort_mosi", 32'(spi_mosi), 32'd1);
        chk("abort_tgt", 32'(spi_tgt), 32'd0);
        chk("abort_sd_rdy", 32'(sd_rdy), 32'd1);
        chk("abort_sd_dout", 32'(sd_dout), 32'hFF);
        chk("abort_mc_dout", 32'(mc_dout), 32'hFF);
        repeat (2) @(posedge cpu_clock);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge cpu_clock);
        #1;
        chk("post_rst_tgt", 32'(spi_tgt), 32'd0);
        chk("post_rst_obs", 32'(obs_q.size()), 32'd0);

        // MD starvation under continuous MC restarts
        mc_speed     = 2'b10;
        md_halfspeed = 1'b0;
        mc_din       = 8'h11;
        md_din       = 8'h22;
        exp_push(2'd2, 8'h11, 8);
        exp_push(2'd2, 8'h11, 8);
        exp_push(2'd2, 8'h11, 8);
`ifdef SPI_ARB_ANTISTARVE_EN
        exp_push(2'd3, 8'h22, 8);
        exp_push(2'd2, 8'h11, 8);
`else
        exp_push(2'd2, 8'h11, 8);
        exp_push(2'd3, 8'h22, 8);
`endif
        drive_start(4'b1100);
        for (int g = 0; g < 3; g++) begin
            n = 0;
            while (spi_tgt != 2'd2 && n < 100) begin
                @(posedge cpu_clock);
                #1;
                n++;
            end
            drive_start(4'b0100);
            n = 0;
            while (spi_tgt == 2'd2 && n < 100) begin
                @(posedge cpu_clock);
                #1;
                n++;
            end
        end
        sb_check("stv0");
        sb_check("stv1");
        sb_check("stv2");
        sb_check("stv3");
        sb_check("stv4");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
